das_accumulator: RTL and testbench
==================================

Name: das_accumulator

Overview:
- Delay-and-sum stage directly downstream of the per-pixel delta generator in the ultrasound beamformer.
- Captures one frame of echo samples from the 16 receive channels (4x4 array) into per-channel buffers.
- For each pixel, accepts the 16-entry delta vector and reads sample[ch][delta[ch]] from every channel.
- Sums the 16 samples through a pipelined adder tree and hands the pixel value to the image writer with a valid/ready handshake.

Parameters:
- NCH, 16, number of receive channels; fixed 4x4 geometry, index = row*4+col.
- SAMPLE_W, 12, signed echo sample width.
- DEPTH, 256, samples stored per channel per frame.
- DELTA_W, $clog2(`DELTA_LAST), delta index width.
- SUM_W, SAMPLE_W+4, signed pixel sum width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  pulse; begin capture of a new frame.
- i_smp_valid  in  1  the i_smp vector is valid this cycle.
- i_smp  in  SAMPLE_W x NCH  signed samples, one per channel.
- i_delta_valid  in  1  the i_delta vector is valid.
- o_delta_ready  out  1  the stage accepts a delta vector this cycle.
- i_delta  in  DELTA_W x NCH  per-channel sample index for the current pixel.
- o_pix_valid  out  1  o_pix holds a result.
- i_pix_ready  in  1  downstream accepts o_pix.
- o_pix  out  SUM_W  signed delay-and-sum pixel value.
- o_capture_done  out  1  one-cycle pulse when the frame buffer becomes full.
- o_busy  out  1  high in CAPTURE, or while any pipeline stage is valid.

Behaviour:
- Reset: state IDLE, wr_ptr=0, all pipeline valid bits 0, o_pix=0, o_pix_valid=0, o_delta_ready=0, o_capture_done=0, o_busy=0. Buffer contents are not reset.
- FSM states: IDLE, CAPTURE, BEAM.
- i_start in any state: next state is CAPTURE, wr_ptr=0, all pipeline valid bits cleared (in-flight pixels are dropped).
- i_start takes precedence over i_smp_valid in the same cycle; that sample is not written.
- CAPTURE: each cycle with i_smp_valid, write i_smp[ch] to buf[ch][wr_ptr] for all channels, then wr_ptr++.
  - On the write with wr_ptr==DEPTH-1: pulse o_capture_done in the following cycle and go to BEAM.
- i_smp_valid outside CAPTURE is ignored.
- Pipeline enable: pipe_en = !o_pix_valid || i_pix_ready. All stages stall together.
- o_delta_ready = (state==BEAM) && pipe_en. Acceptance is i_delta_valid && o_delta_ready.
- Stage 1, read: registered buffer read, rd[ch] = buf[ch][i_delta[ch]].
  - If i_delta[ch] >= DEPTH, rd[ch]=0 (sample out of window).
- Stage 2: sign-extend to SUM_W and sum groups of 4 (channels 0-3, 4-7, 8-11, 12-15) into 4 partials.
- Stage 3: sum the 4 partials into o_pix and set o_pix_valid.
- Latency: acceptance in cycle N gives o_pix_valid in cycle N+3 when there is no backpressure. Throughput is 1 pixel per cycle.
- o_pix and o_pix_valid hold stable while o_pix_valid && !i_pix_ready.
- No overflow is possible: 16 x full-scale SAMPLE_W fits in SUM_W.
- A delta vector offered in IDLE or CAPTURE is not accepted. The upstream stage holds it.

Optional Feature:
- Macro: DAS_APODIZE_EN.
- Defined: corner channels 0, 3, 12 and 15 are arithmetic-shifted right by 1 (weight 1/2, rounding toward -inf) after the stage-1 read and before summation. Latency is unchanged.
- Not defined: all channels have weight 1.

Test Plan:
- Reset mid-BEAM with o_pix_valid=1: assert i_rst_n=0 -> o_pix_valid, o_delta_ready and o_busy go 0 immediately (asynchronous); state IDLE.
- Capture buf[ch][n] = n for all ch, then deltas all 10 with i_pix_ready=1 -> o_capture_done pulses once after the 256th sample; o_pix=160 exactly 3 cycles after acceptance.
- Samples all -2048, any deltas -> o_pix=-32768. Without DAS_APODIZE_EN, no wrap.
- Delta vector with ch0=255, ch1=200 (>= DEPTH only if DEPTH=128; run with DEPTH=128), other channels 0 -> ch1 contributes 0; o_pix matches the reference sum.
- i_pix_ready=0 for 5 cycles while 4 vectors are offered -> at most 3 accepted plus the held output; no pixel lost or duplicated; output order preserved.
- i_start while pixels are in flight -> pipeline flushed, no o_pix_valid afterwards; o_delta_ready=0 until the next capture completes.
- DAS_APODIZE_EN defined, samples all 100 -> o_pix=1400 (12x100 + 4x50).

Source files
------------

// File: rtl/das_accumulator_if.sv
// ---------------------------------------------------------------------------
// das_accumulator_if
//   Bundles the frame-capture, delta-vector and pixel-output signals of the
//   delay-and-sum stage.
//   Port summary:
//     i_start        frame start pulse
//     i_smp_valid    sample vector valid
//     i_smp          NCH x SAMPLE_W echo samples, channel index = row*4+col
//     i_delta_valid  delta vector valid
//     o_delta_ready  stage accepts a delta vector this cycle
//     i_delta        NCH x DELTA_W per-channel sample index
//     o_pix_valid    o_pix holds a result
//     i_pix_ready    downstream accepts o_pix
//     o_pix          SUM_W signed pixel value
//     o_capture_done one-cycle pulse when the frame buffer is full
//     o_busy         capture in progress or pipeline occupied
//   Modports: master = upstream/downstream side, slave = the accumulator.
// ---------------------------------------------------------------------------
interface das_accumulator_if #(
    parameter int NCH      = 16,
    parameter int SAMPLE_W = 12,
    parameter int DELTA_W  = 8,
    parameter int SUM_W    = SAMPLE_W + 4
);
    logic                              i_start;
    logic                              i_smp_valid;
    logic [NCH-1:0][SAMPLE_W-1:0]      i_smp;
    logic                              i_delta_valid;
    logic                              o_delta_ready;
    logic [NCH-1:0][DELTA_W-1:0]       i_delta;
    logic                              o_pix_valid;
    logic                              i_pix_ready;
    logic signed [SUM_W-1:0]           o_pix;
    logic                              o_capture_done;
    logic                              o_busy;

    modport master (
        output i_start, i_smp_valid, i_smp, i_delta_valid, i_delta, i_pix_ready,
        input  o_delta_ready, o_pix_valid, o_pix, o_capture_done, o_busy
    );

    modport slave (
        input  i_start, i_smp_valid, i_smp, i_delta_valid, i_delta, i_pix_ready,
        output o_delta_ready, o_pix_valid, o_pix, o_capture_done, o_busy
    );
endinterface

// File: rtl/das_accumulator.sv
// ---------------------------------------------------------------------------
// das_accumulator
//   Delay-and-sum stage of the ultrasound beamformer. Captures one frame of
//   DEPTH samples from each of the 16 receive channels (4x4 array), then for
//   every accepted delta vector reads sample[ch][delta[ch]] from each channel
//   buffer and sums the 16 values through a 3-stage pipeline
//   (read -> 4 partial sums -> final sum).
//   Ports:
//     i_clk    clock
//     i_rst_n  asynchronous active-low reset
//     bus      das_accumulator_if.slave (capture, delta and pixel handshakes)
//   Optional feature macro: DAS_APODIZE_EN
//     defined     -> corner channels 0, 3, 12, 15 weighted by 1/2
//                    (arithmetic shift right, rounds toward -inf)
//     not defined -> all channels weight 1
// ---------------------------------------------------------------------------
module das_accumulator #(
    parameter int NCH      = 16,
    parameter int SAMPLE_W = 12,
    parameter int DEPTH    = 256,
    parameter int DELTA_W  = 8,
    parameter int SUM_W    = SAMPLE_W + 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    das_accumulator_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        BEAM    = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [AW-1:0]           wr_ptr_reg;
    logic                    capture_done_reg;
    logic                    s1_valid_reg;
    logic                    s2_valid_reg;
    logic                    pix_valid_reg;
    logic signed [SUM_W-1:0] part_reg [4];
    logic signed [SUM_W-1:0] pix_reg;
    logic signed [SUM_W-1:0] weighted [NCH];

    logic pipe_en;
    logic delta_ready;
    logic accept;
    logic wr_en;

    // All stages advance together; a held output freezes the whole pipe.
    assign pipe_en     = !pix_valid_reg || bus.i_pix_ready;
    assign delta_ready = (state_reg == BEAM) && pipe_en;
    assign accept      = bus.i_delta_valid && delta_ready;
    // A start pulse wins over a sample arriving in the same cycle.
    assign wr_en       = (state_reg == CAPTURE) && bus.i_smp_valid && !bus.i_start;

    // ------------------------------------------------------------------
    // Control FSM: frame capture sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg        <= IDLE;
            wr_ptr_reg       <= '0;
            capture_done_reg <= 1'b0;
        end else begin
            capture_done_reg <= 1'b0;
            if (bus.i_start) begin
                state_reg  <= CAPTURE;
                wr_ptr_reg <= '0;
            end else if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (wr_ptr_reg == AW'(DEPTH - 1)) begin
                    state_reg        <= BEAM;
                    capture_done_reg <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel sample buffers, registered read, window check, weighting
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [SAMPLE_W-1:0]     mem [DEPTH];
        logic [SAMPLE_W-1:0]     rd_reg;
        logic                    in_range_reg;
        logic [AW-1:0]           rd_addr;
        logic                    in_range;
        logic signed [SUM_W-1:0] ext;

        assign rd_addr = bus.i_delta[gi][AW-1:0];

        // Only needed when the delta index can address past the buffer.
        if (DEPTH < (1 << DELTA_W)) begin : g_chk
            assign in_range = ({1'b0, bus.i_delta[gi]} < (DELTA_W + 1)'(DEPTH));
        end else begin : g_nochk
            assign in_range = 1'b1;
        end

        always_ff @(posedge i_clk) begin
            if (wr_en) begin
                mem[wr_ptr_reg] <= bus.i_smp[gi];
            end
        end

        // Buffer contents and read data carry no reset (block RAM style).
        always_ff @(posedge i_clk) begin
            if (pipe_en) begin
                rd_reg       <= mem[rd_addr];
                in_range_reg <= in_range;
            end
        end

        assign ext = {{(SUM_W - SAMPLE_W){rd_reg[SAMPLE_W-1]}}, rd_reg};

`ifdef DAS_APODIZE_EN
        if (gi == 0 || gi == 3 || gi == NCH - 4 || gi == NCH - 1) begin : g_corner
            assign weighted[gi] = in_range_reg ? (ext >>> 1) : '0;
        end else begin : g_inner
            assign weighted[gi] = in_range_reg ? ext : '0;
        end
`else
        assign weighted[gi] = in_range_reg ? ext : '0;
`endif
    end

    // ------------------------------------------------------------------
    // Valid chain and adder tree (stage 2: groups of 4, stage 3: total)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            pix_valid_reg <= 1'b0;
            pix_reg       <= '0;
            for (int g = 0; g < 4; g++) begin
                part_reg[g] <= '0;
            end
        end else if (bus.i_start) begin
            // New frame: drop everything in flight.
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            pix_valid_reg <= 1'b0;
        end else if (pipe_en) begin
            s1_valid_reg  <= accept;
            s2_valid_reg  <= s1_valid_reg;
            pix_valid_reg <= s2_valid_reg;
            for (int g = 0; g < 4; g++) begin
                part_reg[g] <= weighted[4*g] + weighted[4*g+1]
                             + weighted[4*g+2] + weighted[4*g+3];
            end
            pix_reg <= part_reg[0] + part_reg[1] + part_reg[2] + part_reg[3];
        end
    end

    assign bus.o_delta_ready  = delta_ready;
    assign bus.o_pix_valid    = pix_valid_reg;
    assign bus.o_pix          = pix_reg;
    assign bus.o_capture_done = capture_done_reg;
    assign bus.o_busy         = (state_reg == CAPTURE) || s1_valid_reg
                              || s2_valid_reg || pix_valid_reg;
endmodule

// File: tb/tb_das_accumulator.sv
`timescale 1ns/1ps
module tb_das_accumulator;
    localparam int NCH      = 16;
    localparam int SAMPLE_W = 12;
    localparam int DELTA_W  = 8;
    localparam int SUM_W    = 16;
    localparam int DEPTH    = 256;
    localparam int DEPTH_B  = 128;

`ifdef DAS_APODIZE_EN
    localparam bit APOD = 1'b1;
`else
    localparam bit APOD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    das_accumulator_if #(.NCH(NCH), .SAMPLE_W(SAMPLE_W), .DELTA_W(DELTA_W), .SUM_W(SUM_W)) ifa();
    das_accumulator_if #(.NCH(NCH), .SAMPLE_W(SAMPLE_W), .DELTA_W(DELTA_W), .SUM_W(SUM_W)) ifb();

    das_accumulator #(.NCH(NCH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .DELTA_W(DELTA_W), .SUM_W(SUM_W))
        dut (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa.slave));
    das_accumulator #(.NCH(NCH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH_B), .DELTA_W(DELTA_W), .SUM_W(SUM_W))
        dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb.slave));

    int checks = 0;
    int passed = 0;

    // Channel weight: corners halved (floor) when apodization is built in.
    function automatic int wt(input int ch, input int v);
        if (APOD && (ch == 0 || ch == 3 || ch == 12 || ch == 15)) return v >>> 1;
        return v;
    endfunction

    // Reference pixel for a buffer holding sample[ch][n] = n + off.
    function automatic int ref_sum(input int d[16], input int depth, input int off);
        int s = 0;
        for (int c = 0; c < 16; c++) if (d[c] < depth) s += wt(c, d[c] + off);
        return s;
    endfunction

    task automatic drive_delta_a(input int d[16]);
        for (int c = 0; c < NCH; c++) ifa.i_delta[c] = DELTA_W'(d[c]);
    endtask

    // Capture a full frame into dut; ramp -> sample n, else constant val.
    task automatic do_capture(input bit ramp, input int val, output int done_cnt,
                              output int rdy_cnt, output int pv_cnt, output int busy_cnt);
        done_cnt = 0; rdy_cnt = 0; pv_cnt = 0; busy_cnt = 0;
        ifa.i_start = 1'b1;
        @(negedge clk);
        ifa.i_start = 1'b0;
        for (int n = 0; n < DEPTH; n++) begin
            ifa.i_smp_valid = 1'b1;
            for (int c = 0; c < NCH; c++) ifa.i_smp[c] = SAMPLE_W'(ramp ? n : val);
            #1;
            if (ifa.o_delta_ready)  rdy_cnt++;
            if (ifa.o_pix_valid)    pv_cnt++;
            if (ifa.o_capture_done) done_cnt++;
            if (ifa.o_busy)         busy_cnt++;
            @(negedge clk);
        end
        ifa.i_smp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (ifa.o_capture_done) done_cnt++;
            if (ifa.o_pix_valid)    pv_cnt++;
            @(negedge clk);
        end
    endtask

    // Offer one delta vector with i_pix_ready=1; report value and latency.
    task automatic run_pixel_a(input int d[16], output int pix, output int lat);
        int waitc = 0;
        drive_delta_a(d);
        ifa.i_delta_valid = 1'b1;
        #1;
        while (!ifa.o_delta_ready && waitc < 20) begin
            @(negedge clk); #1; waitc++;
        end
        if (!ifa.o_delta_ready) begin
            ifa.i_delta_valid = 1'b0;
            pix = 99999; lat = 99;
            return;
        end
        @(negedge clk);
        ifa.i_delta_valid = 1'b0;
        lat = 1;
        while (!ifa.o_pix_valid && lat < 20) begin
            @(negedge clk); lat++;
        end
        pix = int'(ifa.o_pix);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (ifa.o_pix_valid !== 1'b0) $display("FAIL reset_pix_valid: got %0b expected 0", ifa.o_pix_valid); else passed++;
        checks++; if (ifa.o_delta_ready !== 1'b0) $display("FAIL reset_delta_ready: got %0b expected 0", ifa.o_delta_ready); else passed++;
        checks++; if (ifa.o_busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", ifa.o_busy); else passed++;
        checks++; if (ifa.o_capture_done !== 1'b0) $display("FAIL reset_capture_done: got %0b expected 0", ifa.o_capture_done); else passed++;
        checks++; if (ifa.o_pix !== 16'sd0) $display("FAIL reset_pix: got %0d expected 0", ifa.o_pix); else passed++;
        rst_n = 1'b1;
        ifa.i_delta_valid = 1'b1;
        #1;
        checks++; if (ifa.o_delta_ready !== 1'b0) $display("FAIL idle_delta_ready: got %0b expected 0", ifa.o_delta_ready); else passed++;
        ifa.i_delta_valid = 1'b0;
        @(negedge clk);
        $display("reset: outputs idle");
    endtask

    task automatic test_capture_and_latency();
        int dc, rc, pc, bc, pix, lat;
        int d[16];
        ifa.i_pix_ready = 1'b1;
        do_capture(1'b1, 0, dc, rc, pc, bc);
        checks++; if (dc !== 1) $display("FAIL capture_done_pulses: got %0d expected 1", dc); else passed++;
        checks++; if (bc !== DEPTH) $display("FAIL capture_busy_cycles: got %0d expected %0d", bc, DEPTH); else passed++;
        checks++; if (rc !== 0) $display("FAIL capture_delta_ready: got %0d expected 0", rc); else passed++;
        for (int c = 0; c < 16; c++) d[c] = 10;
        run_pixel_a(d, pix, lat);
        checks++; if (lat !== 3) $display("FAIL latency: got %0d expected 3", lat); else passed++;
        checks++; if (pix !== ref_sum(d, DEPTH, 0)) $display("FAIL ramp_delta10: got %0d expected %0d", pix, ref_sum(d, DEPTH, 0)); else passed++;
        checks++; if (ifa.o_pix_valid !== 1'b0) $display("FAIL pix_single_cycle: got %0b expected 0", ifa.o_pix_valid); else passed++;
        $display("capture+latency: done=%0d lat=%0d pix=%0d", dc, lat, pix);
    endtask

    task automatic test_back_to_back();
        int d[3][16];
        int exp_v[3];
        int got_v[$];
        int got_c[$];
        for (int c = 0; c < 16; c++) begin
            d[0][c] = 0; d[1][c] = 255; d[2][c] = c * 10;
        end
        for (int v = 0; v < 3; v++) exp_v[v] = ref_sum(d[v], DEPTH, 0);
        ifa.i_pix_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 3) begin
                drive_delta_a(d[i]);
                ifa.i_delta_valid = 1'b1;
            end else begin
                ifa.i_delta_valid = 1'b0;
            end
            #1;
            if (i < 3) begin
                checks++; if (ifa.o_delta_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %0b expected 1", i, ifa.o_delta_ready); else passed++;
            end
            if (ifa.o_pix_valid) begin
                got_v.push_back(int'(ifa.o_pix));
                got_c.push_back(i);
            end
            @(negedge clk);
        end
        checks++; if (got_v.size() !== 3) $display("FAIL b2b_count: got %0d expected 3", got_v.size()); else passed++;
        for (int v = 0; v < 3 && v < got_v.size(); v++) begin
            checks++; if (got_v[v] !== exp_v[v]) $display("FAIL b2b_value_%0d: got %0d expected %0d", v, got_v[v], exp_v[v]); else passed++;
            checks++; if (got_c[v] !== v + 3) $display("FAIL b2b_cycle_%0d: got %0d expected %0d", v, got_c[v], v + 3); else passed++;
        end
        $display("back_to_back: %0d pixels collected", got_v.size());
    endtask

    task automatic test_backpressure();
        int d[16];
        int got[$];
        int nv = 0, acc_stall = 0, held_bad = 0;
        bit accepted;
        int exp1;
        for (int c = 0; c < 16; c++) d[c] = 1;
        exp1 = ref_sum(d, DEPTH, 0);
        for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
            ifa.i_pix_ready = (cyc >= 5);
            if (nv < 4) begin
                for (int c = 0; c < 16; c++) d[c] = nv + 1;
                drive_delta_a(d);
                ifa.i_delta_valid = 1'b1;
            end else begin
                ifa.i_delta_valid = 1'b0;
            end
            #1;
            accepted = ifa.i_delta_valid && ifa.o_delta_ready;
            if (ifa.o_pix_valid && ifa.i_pix_ready) got.push_back(int'(ifa.o_pix));
            if (ifa.o_pix_valid && !ifa.i_pix_ready && int'(ifa.o_pix) != exp1) held_bad++;
            @(negedge clk);
            if (accepted) begin
                nv++;
                if (cyc < 5) acc_stall++;
            end
        end
        ifa.i_delta_valid = 1'b0;
        ifa.i_pix_ready = 1'b1;
        checks++; if (acc_stall !== 3) $display("FAIL stall_accepts: got %0d expected 3", acc_stall); else passed++;
        checks++; if (held_bad !== 0) $display("FAIL held_output: got %0d unstable cycles expected 0", held_bad); else passed++;
        checks++; if (got.size() !== 4) $display("FAIL stall_count: got %0d expected 4", got.size()); else passed++;
        for (int v = 0; v < 4 && v < got.size(); v++) begin
            for (int c = 0; c < 16; c++) d[c] = v + 1;
            checks++; if (got[v] !== ref_sum(d, DEPTH, 0)) $display("FAIL stall_order_%0d: got %0d expected %0d", v, got[v], ref_sum(d, DEPTH, 0)); else passed++;
        end
        @(negedge clk);
        $display("backpressure: accepted during stall=%0d, delivered=%0d", acc_stall, got.size());
    endtask

    task automatic test_full_scale();
        int dc, rc, pc, bc, pix, lat, e;
        int d[16];
        int vals[2];
        vals[0] = -2048; vals[1] = 2047;
        for (int c = 0; c < 16; c++) d[c] = (c * 37) % 256;
        for (int k = 0; k < 2; k++) begin
            do_capture(1'b0, vals[k], dc, rc, pc, bc);
            run_pixel_a(d, pix, lat);
            e = 0;
            for (int c = 0; c < 16; c++) e += wt(c, vals[k]);
            checks++; if (pix !== e) $display("FAIL full_scale_%0d: got %0d expected %0d", vals[k], pix, e); else passed++;
            $display("full_scale: sample=%0d pix=%0d", vals[k], pix);
        end
    endtask

    task automatic test_apodize();
        int dc, rc, pc, bc, pix, lat, e;
        int d[16];
        for (int c = 0; c < 16; c++) d[c] = c * 3;
        do_capture(1'b0, 100, dc, rc, pc, bc);
        run_pixel_a(d, pix, lat);
        e = APOD ? 1400 : 1600;
        checks++; if (pix !== e) $display("FAIL weight_100: got %0d expected %0d", pix, e); else passed++;
        $display("weights: sample=100 pix=%0d", pix);
    endtask

    task automatic test_flush();
        int dc, rc, pc, bc, acc;
        int d[16];
        acc = 0;
        ifa.i_pix_ready = 1'b1;
        for (int c = 0; c < 16; c++) d[c] = 20;
        drive_delta_a(d);
        for (int i = 0; i < 2; i++) begin
            ifa.i_delta_valid = 1'b1;
            #1;
            if (ifa.o_delta_ready) acc++;
            @(negedge clk);
        end
        ifa.i_delta_valid = 1'b0;
        checks++; if (acc !== 2) $display("FAIL flush_setup_accepts: got %0d expected 2", acc); else passed++;
        do_capture(1'b1, 0, dc, rc, pc, bc);
        checks++; if (pc !== 0) $display("FAIL flush_pix_valid: got %0d cycles expected 0", pc); else passed++;
        checks++; if (rc !== 0) $display("FAIL flush_delta_ready: got %0d cycles expected 0", rc); else passed++;
        checks++; if (dc !== 1) $display("FAIL flush_capture_done: got %0d expected 1", dc); else passed++;
        #1;
        checks++; if (ifa.o_delta_ready !== 1'b1) $display("FAIL flush_ready_after: got %0b expected 1", ifa.o_delta_ready); else passed++;
        @(negedge clk);
        $display("flush: pix_valid cycles=%0d ready cycles=%0d", pc, rc);
    endtask

    task automatic test_window();
        int d[2][16];
        int pix, e, lat;
        ifb.i_pix_ready = 1'b1;
        ifb.i_start = 1'b1;
        @(negedge clk);
        ifb.i_start = 1'b0;
        for (int n = 0; n < DEPTH_B; n++) begin
            ifb.i_smp_valid = 1'b1;
            for (int c = 0; c < NCH; c++) ifb.i_smp[c] = SAMPLE_W'(n + 100);
            @(negedge clk);
        end
        ifb.i_smp_valid = 1'b0;
        checks++; if (ifb.o_capture_done !== 1'b1) $display("FAIL window_capture_done: got %0b expected 1", ifb.o_capture_done); else passed++;
        for (int c = 0; c < 16; c++) begin
            d[0][c] = 0; d[1][c] = 5;
        end
        d[0][0] = 255; d[0][1] = 200;
        d[1][0] = 127; d[1][1] = 128;
        for (int v = 0; v < 2; v++) begin
            for (int c = 0; c < NCH; c++) ifb.i_delta[c] = DELTA_W'(d[v][c]);
            ifb.i_delta_valid = 1'b1;
            #1;
            checks++; if (ifb.o_delta_ready !== 1'b1) $display("FAIL window_ready_%0d: got %0b expected 1", v, ifb.o_delta_ready); else passed++;
            @(negedge clk);
            ifb.i_delta_valid = 1'b0;
            lat = 1;
            while (!ifb.o_pix_valid && lat < 20) begin
                @(negedge clk); lat++;
            end
            pix = int'(ifb.o_pix);
            e = ref_sum(d[v], DEPTH_B, 100);
            checks++; if (pix !== e || lat !== 3) $display("FAIL window_pix_%0d: got %0d (lat %0d) expected %0d (lat 3)", v, pix, lat, e); else passed++;
            $display("window: vector %0d pix=%0d", v, pix);
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        int d[16];
        int waitc = 0;
        for (int c = 0; c < 16; c++) d[c] = 7;
        drive_delta_a(d);
        ifa.i_pix_ready = 1'b0;
        ifa.i_delta_valid = 1'b1;
        @(negedge clk);
        ifa.i_delta_valid = 1'b0;
        while (!ifa.o_pix_valid && waitc < 20) begin
            @(negedge clk); waitc++;
        end
        checks++; if (ifa.o_pix_valid !== 1'b1) $display("FAIL areset_setup_valid: got %0b expected 1", ifa.o_pix_valid); else passed++;
        ifa.i_delta_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ifa.o_pix_valid !== 1'b0) $display("FAIL areset_pix_valid: got %0b expected 0", ifa.o_pix_valid); else passed++;
        checks++; if (ifa.o_delta_ready !== 1'b0) $display("FAIL areset_delta_ready: got %0b expected 0", ifa.o_delta_ready); else passed++;
        checks++; if (ifa.o_busy !== 1'b0) $display("FAIL areset_busy: got %0b expected 0", ifa.o_busy); else passed++;
        checks++; if (ifa.o_pix !== 16'sd0) $display("FAIL areset_pix: got %0d expected 0", ifa.o_pix); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        ifa.i_pix_ready = 1'b1;
        #1;
        checks++; if (ifa.o_delta_ready !== 1'b0) $display("FAIL areset_idle_ready: got %0b expected 0", ifa.o_delta_ready); else passed++;
        @(negedge clk);
        checks++; if (ifa.o_pix_valid !== 1'b0 || ifa.o_busy !== 1'b0) $display("FAIL areset_idle_quiet: got valid=%0b busy=%0b expected 0/0", ifa.o_pix_valid, ifa.o_busy); else passed++;
        ifa.i_delta_valid = 1'b0;
        $display("async_reset: outputs cleared, state idle");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.i_start = 1'b0; ifa.i_smp_valid = 1'b0; ifa.i_smp = '0;
        ifa.i_delta_valid = 1'b0; ifa.i_delta = '0; ifa.i_pix_ready = 1'b1;
        ifb.i_start = 1'b0; ifb.i_smp_valid = 1'b0; ifb.i_smp = '0;
        ifb.i_delta_valid = 1'b0; ifb.i_delta = '0; ifb.i_pix_ready = 1'b1;
        test_reset();
        test_capture_and_latency();
        test_back_to_back();
        test_backpressure();
        test_full_scale();
        test_apodize();
        test_flush();
        test_window();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
